// File: rtl/mdu_if.sv
// Multiply/divide unit bus: forwarded operands and opcode in, busy/read-back/HI/LO out.
interface mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MdOp;
  logic        Req;
  logic        Busy;
  logic [31:0] Out;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output A, B, MdOp, Req,
    input  Busy, Out, HI, LO
  );

  modport slave (
    input  A, B, MdOp, Req,
    output Busy, Out, HI, LO
  );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with private HI/LO registers.
// The result is computed at the accepting edge and held in pHI/pLO; it only
// becomes architectural when the busy countdown expires.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  typedef enum logic { S_IDLE, S_RUN } state_t;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } md_op_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        phi_q, phi_d;
  logic [31:0]        plo_q, plo_d;
  logic               pvalid_q, pvalid_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               busy_q, busy_d;

  md_op_t             op;
  logic [63:0]        prod_s, prod_u;
  logic               div_signed;
  logic [31:0]        div_a, div_b, uq, ur, quot, rem;

  assign op = md_op_t'(bus.MdOp);

  // Arithmetic datapath: products and a sign-magnitude divider.
  // Signed divide runs on magnitudes so 0x80000000 / -1 falls out as 0x80000000
  // without relying on signed-overflow behaviour of the '/' operator.
  always_comb begin
    prod_u     = {32'd0, bus.A} * {32'd0, bus.B};
    prod_s     = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    div_signed = (op == OP_DIV);
    div_a      = (div_signed && bus.A[31]) ? (~bus.A + 32'd1) : bus.A;
    div_b      = (div_signed && bus.B[31]) ? (~bus.B + 32'd1) : bus.B;
    uq         = '0;
    ur         = '0;
    if (div_b != '0) begin
      uq = div_a / div_b;
      ur = div_a % div_b;
    end
    quot = (div_signed && (bus.A[31] ^ bus.B[31])) ? (~uq + 32'd1) : uq;
    rem  = (div_signed && bus.A[31]) ? (~ur + 32'd1) : ur;
  end

  // Next-state: accept/MTHI/MTLO in IDLE, countdown and commit in RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phi_d    = phi_q;
    plo_d    = plo_q;
    pvalid_d = pvalid_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.Req) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              {phi_d, plo_d} = (op == OP_MULT) ? prod_s : prod_u;
              pvalid_d = 1'b1;
              cnt_d    = CNT_W'(MULT_CYCLES);
              state_d  = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              phi_d    = rem;
              plo_d    = quot;
              pvalid_d = (bus.B != '0);
              cnt_d    = CNT_W'(DIV_CYCLES);
              state_d  = S_RUN;
            end
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 1'b1;
        // <= 1 rather than == 1 so a zero cycle parameter cannot wedge the unit.
        if (cnt_q <= CNT_W'(1)) begin
          if (pvalid_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
          cnt_d    = '0;
          pvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
  end

  // State, pending result and architectural HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      phi_q    <= '0;
      plo_q    <= '0;
      pvalid_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phi_q    <= phi_d;
      plo_q    <= plo_d;
      pvalid_q <= pvalid_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
    end
  end

  // Read-back mux: architectural registers only, never pending values.
  always_comb begin
    bus.Out = '0;
    if (op == OP_MFHI)      bus.Out = hi_q;
    else if (op == OP_MFLO) bus.Out = lo_q;
  end

  assign bus.Busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: vector table through a scoreboard queue, plus
// hand-written sequences for MTHI-while-busy, Req flush, divide-by-zero and reset abort.
module tb_mdu;

  logic clk;
  logic reset;
  mdu_if bus ();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  vec_t vecs[7];
  res_t sb[$];
  res_t exp_r;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for one edge; leave the bus idle afterwards.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic req);
    bus.MdOp = op;
    bus.A    = a;
    bus.B    = b;
    bus.Req  = req;
    tick();
    bus.MdOp = 4'd0;
    bus.Req  = 1'b0;
  endtask

  // Count cycles Busy is observed high after the accepting edge, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.Busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  int n;

  initial begin
    vecs[0] = '{4'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[4] = '{4'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    vecs[5] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[6] = '{4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};

    bus.A = '0; bus.B = '0; bus.MdOp = 4'd0; bus.Req = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();

    chk("reset_busy", {31'd0, bus.Busy}, 32'd0);
    chk("reset_hi",   bus.HI, 32'd0);
    chk("reset_lo",   bus.LO, 32'd0);
    chk("reset_out",  bus.Out, 32'd0);

    // Table-driven vectors through the scoreboard.
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{vecs[i].hi, vecs[i].lo});
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      count_busy(n);
      chk($sformatf("v%0d_busy_cycles", i), n, vecs[i].cycles);
      exp_r = sb.pop_front();
      chk($sformatf("v%0d_hi", i), bus.HI, exp_r.hi);
      chk($sformatf("v%0d_lo", i), bus.LO, exp_r.lo);
      bus.MdOp = 4'd6; #1;
      chk($sformatf("v%0d_mflo", i), bus.Out, exp_r.lo);
      bus.MdOp = 4'd5; #1;
      chk($sformatf("v%0d_mfhi", i), bus.Out, exp_r.hi);
      bus.MdOp = 4'd0;
      tick();
    end

    // MTHI during a busy MULT is ignored; MFHI while busy returns the old HI.
    // HI currently 0x3FFFFFFF from the last vector.
    issue(4'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
    bus.MdOp = 4'd5; #1;
    chk("mfhi_while_busy", bus.Out, 32'h3FFFFFFF);
    issue(4'd7, 32'h0000ABCD, 32'd0, 1'b0);
    chk("hi_after_mthi_busy", bus.HI, 32'h3FFFFFFF);
    count_busy(n);
    chk("mthi_busy_hi_final", bus.HI, 32'hFFFFFFFF);
    chk("mthi_busy_lo_final", bus.LO, 32'hFFFFFFF1);

    // MULTU held on the bus throughout RUN, including the commit edge: ignored.
    issue(4'd1, 32'd4, 32'd4, 1'b0);
    bus.MdOp = 4'd2; bus.A = 32'd3; bus.B = 32'd3;
    count_busy(n);
    bus.MdOp = 4'd0;
    chk("hold_op_busy_cycles", n, 5);
    tick();
    chk("hold_op_no_restart", {31'd0, bus.Busy}, 32'd0);
    chk("hold_op_lo", bus.LO, 32'd16);

    // Req=1 suppresses MTHI and a start.
    issue(4'd7, 32'h0000ABCD, 32'd0, 1'b1);
    chk("mthi_req_hi", bus.HI, 32'd0);
    issue(4'd1, 32'd2, 32'd3, 1'b1);
    chk("start_req_busy", {31'd0, bus.Busy}, 32'd0);

    // MTHI/MTLO one-edge latency, then DIVU by zero leaves them unchanged.
    issue(4'd7, 32'h11, 32'd0, 1'b0);
    chk("mthi_hi", bus.HI, 32'h11);
    issue(4'd8, 32'h22, 32'd0, 1'b0);
    chk("mtlo_lo", bus.LO, 32'h22);
    issue(4'd4, 32'd7, 32'd0, 1'b0);
    count_busy(n);
    chk("div0_busy_cycles", n, 10);
    chk("div0_hi", bus.HI, 32'h11);
    chk("div0_lo", bus.LO, 32'h22);

    // Reset mid-RUN aborts immediately; no commit follows.
    issue(4'd1, 32'd6, 32'd7, 1'b0);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, bus.Busy}, 32'd0);
    chk("rst_mid_hi", bus.HI, 32'd0);
    chk("rst_mid_lo", bus.LO, 32'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chk("rst_after_busy", {31'd0, bus.Busy}, 32'd0);
    chk("rst_after_lo", bus.LO, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
